// File: rtl/freq_scaler_if.sv
// Signal bundle between the pad logic / display stage and freq_scaler.
// The design drives the measurement and generated-wave outputs; the
// surrounding logic drives the input wave and the control inputs.
interface freq_scaler_if #(
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = 3
);
    logic               infreq;
    logic               adjust;
    logic               mode;
    logic [SHIFT_W-1:0] n;
    logic               outfreq;
    logic               valid;
    logic [CNT_W-1:0]   period;
    logic [CNT_W-1:0]   half;
    logic               err;
    logic               clamp;

    modport master (
        output infreq, adjust, mode, n,
        input  outfreq, valid, period, half, err, clamp
    );

    modport slave (
        input  infreq, adjust, mode, n,
        output outfreq, valid, period, half, err, clamp
    );
endinterface

// File: rtl/freq_scaler.sv
// Frequency scaler: measures the period of a slow input square wave in clk
// cycles, then regenerates a square wave whose frequency is the input
// frequency multiplied (mode=0) or divided (mode=1) by 2^n.
module freq_scaler #(
    parameter int CNT_W   = 16,
    parameter int SHIFT_W = 3
) (
    input  logic          clk,
    input  logic          rst,
    freq_scaler_if.slave  bus
);

    localparam int WIDE_W = CNT_W + 2**SHIFT_W;
    localparam logic [CNT_W-1:0]   CNT_ONE      = 1;
    localparam logic [SHIFT_W:0]   SH_ONE       = 1;
    localparam logic [WIDE_W-1:0]  CNT_MAX_WIDE = {{(WIDE_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE, HOLD, ARM, MEAS, LOAD, RUN, ERR
    } state_t;

    state_t           state_q,   state_d;
    logic             sync1_q,   sync1_d;
    logic             sync2_q,   sync2_d;
    logic             prev_q,    prev_d;
    logic [CNT_W-1:0] pcnt_q,    pcnt_d;
    logic [CNT_W-1:0] dcnt_q,    dcnt_d;
    logic [CNT_W-1:0] period_q,  period_d;
    logic [CNT_W-1:0] half_q,    half_d;
    logic             outfreq_q, outfreq_d;
    logic             valid_q,   valid_d;
    logic             err_q,     err_d;
    logic             clamp_q,   clamp_d;

    logic              rise;
    logic [WIDE_W-1:0] p_wide;
    logic [WIDE_W-1:0] h_wide;
    logic [SHIFT_W:0]  div_shift;
    logic [CNT_W-1:0]  h_val;
    logic              h_clamp;

    // Half-period from the measured period, computed wide so the multiply
    // direction cannot lose bits before the range check clamps it.
    always_comb begin
        p_wide    = {{(WIDE_W-CNT_W){1'b0}}, period_q};
        div_shift = {1'b0, bus.n} + SH_ONE;
        if (bus.mode) begin
            h_wide = (p_wide << bus.n) >> 1;
        end else begin
            h_wide = p_wide >> div_shift;
        end
        h_val   = h_wide[CNT_W-1:0];
        h_clamp = 1'b0;
        if (h_wide == '0) begin
            h_val   = CNT_ONE;
            h_clamp = 1'b1;
        end else if (h_wide > CNT_MAX_WIDE) begin
            h_val   = '1;
            h_clamp = 1'b1;
        end
    end

    // Next-state logic: synchroniser, measurement FSM and wave generator.
    always_comb begin
        sync1_d   = bus.infreq;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        rise      = sync2_q & ~prev_q;
        state_d   = state_q;
        pcnt_d    = pcnt_q;
        dcnt_d    = dcnt_q;
        period_d  = period_q;
        half_d    = half_q;
        outfreq_d = outfreq_q;
        valid_d   = valid_q;
        err_d     = err_q;
        clamp_d   = clamp_q;

        if (bus.adjust && (state_q != HOLD)) begin
            state_d   = HOLD;
            valid_d   = 1'b0;
            outfreq_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end
                HOLD: begin
                    err_d     = 1'b0;
                    clamp_d   = 1'b0;
                    valid_d   = 1'b0;
                    outfreq_d = 1'b0;
                    if (!bus.adjust) begin
                        state_d = ARM;
                    end
                end
                ARM: begin
                    if (rise) begin
                        pcnt_d  = CNT_ONE;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period_d = pcnt_q;
                        state_d  = LOAD;
                    end else if (pcnt_q == '1) begin
                        err_d   = 1'b1;
                        state_d = ERR;
                    end else begin
                        pcnt_d = pcnt_q + CNT_ONE;
                    end
                end
                LOAD: begin
                    half_d    = h_val;
                    dcnt_d    = h_val - CNT_ONE;
                    clamp_d   = h_clamp;
                    valid_d   = 1'b1;
                    outfreq_d = 1'b0;
                    state_d   = RUN;
                end
                RUN: begin
                    valid_d = 1'b1;
                    if (dcnt_q == '0) begin
                        outfreq_d = ~outfreq_q;
                        dcnt_d    = half_q - CNT_ONE;
                    end else begin
                        dcnt_d = dcnt_q - CNT_ONE;
                    end
                end
                ERR: begin
                    valid_d   = 1'b0;
                    outfreq_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            period_q  <= '0;
            half_q    <= '0;
            outfreq_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            clamp_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            period_q  <= period_d;
            half_q    <= half_d;
            outfreq_q <= outfreq_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            clamp_q   <= clamp_d;
        end
    end

    assign bus.outfreq = outfreq_q;
    assign bus.valid   = valid_q;
    assign bus.period  = period_q;
    assign bus.half    = half_q;
    assign bus.err     = err_q;
    assign bus.clamp   = clamp_q;

endmodule

// File: tb/tb_freq_scaler.sv
// Bench for freq_scaler: a 16-bit instance for the measurement and wave
// generation scenarios and an 8-bit instance for overflow and clamping.
module tb_freq_scaler;

    typedef struct {
        int period;
        int half;
        bit clamp;
    } exp_t;

    logic clk;
    logic rst;

    freq_scaler_if #(.CNT_W(16), .SHIFT_W(3)) bus16();
    freq_scaler_if #(.CNT_W(8),  .SHIFT_W(3)) bus8();

    freq_scaler #(.CNT_W(16), .SHIFT_W(3)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    freq_scaler #(.CNT_W(8), .SHIFT_W(3)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    exp_t expQ[$];
    int   totalCount = 0;
    int   badCount   = 0;
    int   genHi16 = 32, genLo16 = 32, phase16 = 0;
    int   genHi8  = 10, genLo8  = 2,  phase8  = 0;
    bit   genOn16 = 1'b0;
    bit   genOn8  = 1'b0;

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Square-wave source for the 16-bit instance, retimed to the falling edge.
    initial begin
        bus16.infreq = 1'b0;
        forever begin
            @(negedge clk);
            if (!genOn16) begin
                bus16.infreq = 1'b0;
                phase16 = 0;
            end else begin
                phase16++;
                if (bus16.infreq && phase16 >= genHi16) begin
                    bus16.infreq = 1'b0;
                    phase16 = 0;
                end else if (!bus16.infreq && phase16 >= genLo16) begin
                    bus16.infreq = 1'b1;
                    phase16 = 0;
                end
            end
        end
    end

    // Square-wave source for the 8-bit instance.
    initial begin
        bus8.infreq = 1'b0;
        forever begin
            @(negedge clk);
            if (!genOn8) begin
                bus8.infreq = 1'b0;
                phase8 = 0;
            end else begin
                phase8++;
                if (bus8.infreq && phase8 >= genHi8) begin
                    bus8.infreq = 1'b0;
                    phase8 = 0;
                end else if (!bus8.infreq && phase8 >= genLo8) begin
                    bus8.infreq = 1'b1;
                    phase8 = 0;
                end
            end
        end
    end

    // Safety net in case something upstream stalls the whole run.
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input longint obs, input longint expv,
                               input int tol = 0);
        longint diff;
        totalCount++;
        diff = obs - expv;
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            badCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d (tolerance %0d)",
                     tag, obs, expv, tol);
        end
    endtask

    task automatic stepSample();
        @(negedge clk);
        #1;
    endtask

    function automatic int modelHalf(input int p, input bit m, input int sh,
                                     input int cntW, output bit cl);
        longint h;
        longint maxv;
        maxv = (longint'(1) << cntW) - 1;
        if (m) h = (longint'(p) << sh) >> 1;
        else   h = longint'(p) >> (sh + 1);
        cl = 1'b0;
        if (h == 0) begin
            h  = 1;
            cl = 1'b1;
        end else if (h > maxv) begin
            h  = maxv;
            cl = 1'b1;
        end
        return int'(h);
    endfunction

    // Pulse adjust on the 16-bit instance and queue the expected measurement.
    task automatic applyStimulus(input bit m, input int sh, input int expPeriod);
        exp_t e;
        bit   cl;
        bus16.mode   = m;
        bus16.n      = 3'(sh);
        bus16.adjust = 1'b1;
        repeat (3) stepSample();
        checkOutput("adj_valid_low",   bus16.valid,   0);
        checkOutput("adj_outfreq_low", bus16.outfreq, 0);
        checkOutput("adj_err_clear",   bus16.err,     0);
        checkOutput("adj_clamp_clear", bus16.clamp,   0);
        e.period = expPeriod;
        e.half   = modelHalf(expPeriod, m, sh, 16, cl);
        e.clamp  = cl;
        expQ.push_back(e);
        bus16.adjust = 1'b0;
    endtask

    // Wait for the 16-bit instance to start generating and score the result.
    task automatic waitResult16(output int halfSeen);
        exp_t e;
        int   c;
        halfSeen = 0;
        c = 0;
        while (!bus16.valid && c < 3000) begin
            stepSample();
            c++;
        end
        checkOutput("valid_rise", bus16.valid, 1);
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 0, 1);
            return;
        end
        e = expQ.pop_front();
        halfSeen = e.half;
        checkOutput("period", bus16.period,  e.period, 1);
        checkOutput("half",   bus16.half,    e.half,   1);
        checkOutput("clamp",  bus16.clamp,   e.clamp);
        checkOutput("run_entry_outfreq", bus16.outfreq, 0);
        c = 0;
        while (bus16.outfreq == 1'b0 && c < 4 * e.half + 20) begin
            stepSample();
            c++;
        end
        checkOutput("first_toggle", c, e.half, 1);
        c = 0;
        while (bus16.outfreq == 1'b1 && c < 4 * e.half + 20) begin
            stepSample();
            c++;
        end
        while (bus16.outfreq == 1'b0 && c < 8 * e.half + 40) begin
            stepSample();
            c++;
        end
        checkOutput("out_period", c, 2 * e.half, 2);
    endtask

    // Wait for the 8-bit instance to start generating and score the result.
    task automatic waitResult8();
        exp_t e;
        int   c;
        c = 0;
        while (!bus8.valid && c < 600) begin
            stepSample();
            c++;
        end
        checkOutput("valid8_rise", bus8.valid, 1);
        if (expQ.size() == 0) begin
            checkOutput("queue_empty", 0, 1);
            return;
        end
        e = expQ.pop_front();
        checkOutput("period8", bus8.period, e.period, 1);
        checkOutput("half8",   bus8.half,   e.half,   1);
        checkOutput("clamp8",  bus8.clamp,  e.clamp);
    endtask

    initial begin
        exp_t e;
        bit   cl;
        bit   saw;
        int   c;
        int   h;

        rst = 1'b0;
        bus16.adjust = 1'b0; bus16.mode = 1'b0; bus16.n = 3'd0;
        bus8.adjust  = 1'b0; bus8.mode  = 1'b0; bus8.n  = 3'd0;

        // Reset values.
        repeat (3) stepSample();
        checkOutput("rst_outfreq", bus16.outfreq, 0);
        checkOutput("rst_valid",   bus16.valid,   0);
        checkOutput("rst_period",  bus16.period,  0);
        checkOutput("rst_half",    bus16.half,    0);
        checkOutput("rst_err",     bus16.err,     0);
        checkOutput("rst_clamp",   bus16.clamp,   0);
        checkOutput("rst8_valid",  bus8.valid,    0);
        checkOutput("rst8_err",    bus8.err,      0);
        rst = 1'b1;

        // Input wave present but no adjust: nothing is generated.
        genHi16 = 32; genLo16 = 32; genOn16 = 1'b1;
        saw = 1'b0;
        repeat (200) begin
            stepSample();
            if (bus16.valid || bus16.outfreq) saw = 1'b1;
        end
        checkOutput("idle_quiet", saw, 0);

        // Period 64, multiply by 4.
        applyStimulus(1'b0, 2, 64);
        waitResult16(h);

        // Control inputs changed during generation are ignored.
        bus16.mode = 1'b1; bus16.n = 3'd5;
        repeat (50) stepSample();
        checkOutput("run_half_hold",  bus16.half,  h, 1);
        checkOutput("run_valid_hold", bus16.valid, 1);

        // Period 64, divide by 2.
        applyStimulus(1'b1, 1, 64);
        waitResult16(h);

        // Period 4, multiply by 8: half clamps to 1.
        genHi16 = 2; genLo16 = 2;
        applyStimulus(1'b0, 3, 4);
        waitResult16(h);

        // Re-measure: run at 64, switch the input to 100 and adjust again.
        genHi16 = 32; genLo16 = 32;
        applyStimulus(1'b0, 2, 64);
        waitResult16(h);
        genHi16 = 50; genLo16 = 50;
        saw = 1'b0;
        repeat (150) begin
            stepSample();
            if (!bus16.valid) saw = 1'b1;
        end
        checkOutput("no_tracking_valid", saw, 0);
        checkOutput("no_tracking_period", bus16.period, 64, 1);
        applyStimulus(1'b0, 1, 100);
        waitResult16(h);

        // Reset in the middle of generation.
        c = 0;
        while (!bus16.outfreq && c < 200) begin
            stepSample();
            c++;
        end
        checkOutput("pre_rst_outfreq", bus16.outfreq, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async_outfreq", bus16.outfreq, 0);
        checkOutput("async_valid",   bus16.valid,   0);
        checkOutput("async_period",  bus16.period,  0);
        checkOutput("async_half",    bus16.half,    0);
        stepSample();
        stepSample();
        rst = 1'b1;
        saw = 1'b0;
        repeat (300) begin
            stepSample();
            if (bus16.valid || bus16.outfreq) saw = 1'b1;
        end
        checkOutput("post_rst_quiet", saw, 0);

        // 8-bit instance: one rise then silence overflows the period counter.
        bus8.adjust = 1'b1;
        repeat (3) stepSample();
        bus8.adjust = 1'b0;
        stepSample();
        genHi8 = 10; genLo8 = 2; genOn8 = 1'b1;
        c = 0;
        while (!bus8.infreq && c < 20) begin
            stepSample();
            c++;
        end
        genLo8 = 1000000;
        c = 0;
        while (!bus8.err && c < 400) begin
            stepSample();
            c++;
        end
        checkOutput("err_latency", c, 258, 1);
        checkOutput("err_set",     bus8.err,     1);
        checkOutput("err_valid",   bus8.valid,   0);
        checkOutput("err_outfreq", bus8.outfreq, 0);

        // Adjust clears the error and a fresh measurement follows.
        bus8.mode = 1'b0; bus8.n = 3'd0; bus8.adjust = 1'b1;
        repeat (3) stepSample();
        checkOutput("err_cleared", bus8.err,   0);
        checkOutput("hold8_valid", bus8.valid, 0);
        genHi8 = 20; genLo8 = 20;
        e.period = 40;
        e.half   = modelHalf(40, 1'b0, 0, 8, cl);
        e.clamp  = cl;
        expQ.push_back(e);
        bus8.adjust = 1'b0;
        waitResult8();

        // Divide far enough that the half-period exceeds 8 bits and clamps.
        bus8.mode = 1'b1; bus8.n = 3'd4; bus8.adjust = 1'b1;
        repeat (3) stepSample();
        e.period = 40;
        e.half   = modelHalf(40, 1'b1, 4, 8, cl);
        e.clamp  = cl;
        expQ.push_back(e);
        bus8.adjust = 1'b0;
        waitResult8();

        checkOutput("queue_drained", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule
